// File: rtl/usb_rx_deserializer.sv
// usb_rx_deserializer: width-generic serial-to-parallel converter feeding a one-entry valid/ready holding buffer.
// Stuffed bits are discarded; a completed word that finds the buffer occupied is dropped and flagged as overrun.
module usb_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CW = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  shift_enable,
  input  logic                  stuff_bit,
  input  logic                  d_orig,
  output logic [DATA_WIDTH-1:0] rcv_data,
  output logic [CW-1:0]         bit_count,
  output logic [DATA_WIDTH-1:0] word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  overrun
);
  logic [DATA_WIDTH-1:0] rcv_data_q, rcv_data_d, shifted;
  logic [CW-1:0]         bit_count_q, bit_count_d;
  logic [DATA_WIDTH-1:0] word_data_q, word_data_d;
  logic                  word_valid_q, word_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  sample, last_bit, complete, load;

  always_comb begin
    sample       = shift_enable & ~stuff_bit & ~clear;
    shifted      = LSB_FIRST ? {d_orig, rcv_data_q[DATA_WIDTH-1:1]} : {rcv_data_q[DATA_WIDTH-2:0], d_orig};
    last_bit     = bit_count_q == CW'(DATA_WIDTH - 1);
    complete     = sample & last_bit;
    // a word loads if the buffer is empty or being drained on this same edge
    load         = complete & (~word_valid_q | word_ready);
    rcv_data_d   = clear ? '0 : sample ? shifted : rcv_data_q;
    bit_count_d  = clear ? '0 : sample ? (last_bit ? '0 : bit_count_q + 1'b1) : bit_count_q;
    word_data_d  = load ? shifted : word_data_q;
    word_valid_d = load | (word_valid_q & ~word_ready);
    overrun_d    = ~clear & (overrun_q | (complete & ~load));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rcv_data_q   <= '0;
      bit_count_q  <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rcv_data_q   <= rcv_data_d;
      bit_count_q  <= bit_count_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rcv_data   = rcv_data_q;
  assign bit_count  = bit_count_q;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_usb_rx_deserializer.sv
// tb_usb_rx_deserializer: drives a W=8 LSB-first and a W=16 MSB-first instance with the same stream,
// checked against a bit-history model plus a table of fixed expectations for the 8-bit instance.
module tb_usb_rx_deserializer;
  logic clk = 1'b0, n_rst = 1'b0;
  logic clear = 1'b0, shift_enable = 1'b0, stuff_bit = 1'b0, d_orig = 1'b0, word_ready = 1'b0;
  logic [7:0]  rcv8, wd8;
  logic [2:0]  cnt8;
  logic        wv8, ov8;
  logic [15:0] rcv16, wd16;
  logic [3:0]  cnt16;
  logic        wv16, ov16;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  usb_rx_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable), .stuff_bit(stuff_bit),
    .d_orig(d_orig), .rcv_data(rcv8), .bit_count(cnt8), .word_data(wd8), .word_valid(wv8),
    .word_ready(word_ready), .overrun(ov8));

  usb_rx_deserializer #(.DATA_WIDTH(16), .LSB_FIRST(1'b0)) dut16 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable), .stuff_bit(stuff_bit),
    .d_orig(d_orig), .rcv_data(rcv16), .bit_count(cnt16), .word_data(wd16), .word_valid(wv16),
    .word_ready(word_ready), .overrun(ov16));

  // model: every accepted bit since the last clear, indexed by arrival order
  int          wid[2] = '{8, 16};
  bit          lsb[2] = '{1'b1, 1'b0};
  bit          hist[2][4096];
  int          ns[2];
  logic [31:0] m_wd[2];
  bit          m_wv[2], m_ov[2];

  function automatic logic [31:0] compose(int i);
    logic [31:0] v = '0;
    for (int k = 0; k < wid[i]; k++) begin
      int idx = lsb[i] ? ns[i] - wid[i] + k : ns[i] - 1 - k;
      if (idx >= 0) v[k] = hist[i][idx % 4096];
    end
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      ns[i] = 0; m_wd[i] = '0; m_wv[i] = 1'b0; m_ov[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      bit comp = 1'b0;
      if (clear) begin
        ns[i] = 0; m_ov[i] = 1'b0;
      end else if (shift_enable && !stuff_bit) begin
        hist[i][ns[i] % 4096] = d_orig;
        ns[i]++;
        comp = (ns[i] % wid[i]) == 0;
      end
      if (comp) begin
        if (!m_wv[i] || word_ready) begin
          m_wd[i] = compose(i); m_wv[i] = 1'b1;
        end else m_ov[i] = 1'b1;
      end else if (m_wv[i] && word_ready) m_wv[i] = 1'b0;
    end
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_model();
    chk("rcv8", 32'(rcv8), compose(0));
    chk("cnt8", 32'(cnt8), 32'(ns[0] % 8));
    chk("wd8", 32'(wd8), m_wd[0]);
    chk("wv8", 32'(wv8), 32'(m_wv[0]));
    chk("ov8", 32'(ov8), 32'(m_ov[0]));
    chk("rcv16", 32'(rcv16), compose(1));
    chk("cnt16", 32'(cnt16), 32'(ns[1] % 16));
    chk("wd16", 32'(wd16), m_wd[1]);
    chk("wv16", 32'(wv16), 32'(m_wv[1]));
    chk("ov16", 32'(ov16), 32'(m_ov[1]));
  endfunction

  task automatic step(bit clr_i, bit se_i, bit sb_i, bit d_i, bit rdy_i);
    clear = clr_i; shift_enable = se_i; stuff_bit = sb_i; d_orig = d_i; word_ready = rdy_i;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    bit clr, se, sb, d, rdy;
    int cnt;
    bit full, wv;
    logic [7:0] wd;
    bit ov, rcv_en;
    logic [7:0] rcv;
  } vec_t;
  vec_t tbl[$];

  function automatic void row(bit clr, bit se, bit sb, bit d, bit rdy, int cnt, bit full = 0, bit wv = 0,
                              logic [7:0] wd = 0, bit ov = 0, bit rcv_en = 0, logic [7:0] rcv = 0);
    tbl.push_back('{clr, se, sb, d, rdy, cnt, full, wv, wd, ov, rcv_en, rcv});
  endfunction

  function automatic void sendb(logic [7:0] v, int n, bit rdy);
    for (int k = 0; k < n; k++) row(0, 1, 0, v[k], rdy, k + 1);
  endfunction

  initial begin
    logic [15:0] beef = 16'hBEEF;
    model_reset();
    #3;
    chk("reset_rcv8", 32'(rcv8), 0); chk("reset_cnt8", 32'(cnt8), 0);
    chk("reset_wd8", 32'(wd8), 0); chk("reset_wv8", 32'(wv8), 0); chk("reset_ov8", 32'(ov8), 0);
    chk("reset_wv16", 32'(wv16), 0);
    @(posedge clk); @(negedge clk);
    n_rst = 1'b1;

    sendb(8'hA5, 7, 1);
    row(0, 1, 0, 1, 1, 0, 1, 1, 8'hA5, 0, 1, 8'hA5);
    row(0, 0, 0, 0, 1, 0, 1, 0, 8'hA5, 0);
    sendb(8'hA5, 6, 1);
    row(0, 1, 1, 1, 1, 6);
    row(0, 1, 0, 0, 1, 7);
    row(0, 1, 0, 1, 1, 0, 1, 1, 8'hA5, 0, 1, 8'hA5);
    row(0, 0, 0, 0, 1, 0, 1, 0, 8'hA5, 0);
    sendb(8'h3C, 7, 0);
    row(0, 1, 0, 0, 0, 0, 1, 1, 8'h3C, 0);
    sendb(8'hFF, 7, 0);
    row(0, 1, 0, 1, 0, 0, 1, 1, 8'h3C, 1);
    row(0, 0, 0, 0, 1, 0, 1, 0, 8'h3C, 1);
    row(1, 0, 0, 0, 0, 0, 1, 0, 8'h3C, 0);
    sendb(8'h12, 7, 0);
    row(0, 1, 0, 0, 0, 0, 1, 1, 8'h12, 0);
    sendb(8'h34, 7, 0);
    row(0, 1, 0, 0, 1, 0, 1, 1, 8'h34, 0);
    row(0, 0, 0, 0, 1, 0, 1, 0, 8'h34, 0);
    sendb(8'hFF, 5, 1);
    row(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 8'h00);
    sendb(8'h81, 7, 1);
    row(0, 1, 0, 1, 1, 0, 1, 1, 8'h81, 0, 1, 8'h81);

    // each table row is followed by three idle cycles, giving a sample every fourth cycle
    foreach (tbl[r]) begin
      step(tbl[r].clr, tbl[r].se, tbl[r].sb, tbl[r].d, tbl[r].rdy);
      chk($sformatf("tbl%0d_cnt", r), 32'(cnt8), 32'(tbl[r].cnt));
      if (tbl[r].full) begin
        chk($sformatf("tbl%0d_wv", r), 32'(wv8), 32'(tbl[r].wv));
        chk($sformatf("tbl%0d_wd", r), 32'(wd8), 32'(tbl[r].wd));
        chk($sformatf("tbl%0d_ov", r), 32'(ov8), 32'(tbl[r].ov));
      end
      if (tbl[r].rcv_en) chk($sformatf("tbl%0d_rcv", r), 32'(rcv8), 32'(tbl[r].rcv));
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, tbl[r].rdy);
    end

    step(1, 0, 0, 0, 1);
    for (int k = 15; k >= 0; k--) begin
      step(0, 1, 0, beef[k], 1);
      if (k == 1) chk("beef_cnt15", 32'(cnt16), 15);
    end
    chk("beef_wd", 32'(wd16), 32'hBEEF);
    chk("beef_wv", 32'(wv16), 1);
    chk("beef_cnt0", 32'(cnt16), 0);

    for (int k = 0; k < 11; k++) step(0, 1, 0, k[0], 0);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    model_reset();
    chk("async_rcv8", 32'(rcv8), 0); chk("async_cnt8", 32'(cnt8), 0);
    chk("async_wd8", 32'(wd8), 0); chk("async_wv8", 32'(wv8), 0);
    chk("async_rcv16", 32'(rcv16), 0); chk("async_cnt16", 32'(cnt16), 0);
    #2;
    n_rst = 1'b1;

    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1), $urandom_range(0, 9) == 0,
           $urandom_range(0, 1), $urandom_range(0, 2) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/usb_rx_deserializer.md
Name: usb_rx_deserializer

Overview:
- Parametrised successor to the USB receive-side shift register; width-generic serial-to-parallel converter with selectable bit order.
- Drops stuffed bits, tracks bit position, and hands each completed word to the RX control FSM / FIFO through a one-entry valid/ready holding buffer with overrun detection.
- Sits between the NRZI decoder / bit-stuff detector and the RX FIFO/controller.

Parameters:
- DATA_WIDTH, 8, word width in bits; legal values 2..32.
- LSB_FIRST, 1, 1 = first received bit ends in bit 0 (USB order); 0 = first received bit ends in bit DATA_WIDTH-1.
- CW, $clog2(DATA_WIDTH), bit counter width; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart at SOP/EOP; flushes a partial word.
- shift_enable  in  1  one-cycle strobe marking a bit period sample point.
- stuff_bit  in  1  current sampled bit is a stuffed bit; discard it.
- d_orig  in  1  decoded serial data bit.
- rcv_data  out  DATA_WIDTH  live shift register contents.
- bit_count  out  CW  number of data bits accumulated in the current word (0..DATA_WIDTH-1).
- word_data  out  DATA_WIDTH  holding buffer contents.
- word_valid  out  1  holding buffer holds an unconsumed word.
- word_ready  in  1  consumer accepts word_data this cycle.
- overrun  out  1  sticky; a completed word was dropped.

Behaviour:
- Reset (n_rst=0, async): rcv_data=0, bit_count=0, word_data=0, word_valid=0, overrun=0.
- sample = shift_enable & ~stuff_bit & ~clear. The stuffed bit never shifts and never counts.
- Shift on sample:
  - LSB_FIRST=1: rcv_data <= {d_orig, rcv_data[W-1:1]}.
  - LSB_FIRST=0: rcv_data <= {rcv_data[W-2:0], d_orig}.
- Counter on sample:
  - bit_count < W-1: bit_count <= bit_count+1.
  - bit_count == W-1: word complete; bit_count <= 0 (wrap). rcv_data keeps the full word until later shifts overwrite it.
- Completion load on the same edge:
  - If the holding buffer is empty, or is drained this cycle (word_valid & word_ready), then word_data <= the post-shift value and word_valid <= 1.
  - Otherwise the new word is dropped, word_data is unchanged, and overrun <= 1.
- Latency: word_valid rises on the clock edge following the final sample, i.e. visible the cycle after shift_enable of the last bit.
- Drain: word_valid & word_ready with no completion -> word_valid <= 0 next cycle. word_data is not cleared.
- Simultaneous drain and completion: the new word loads, word_valid stays 1, no overrun.
- clear (highest priority after reset):
  - rcv_data <= 0, bit_count <= 0, overrun <= 0.
  - shift_enable in the same cycle is ignored.
  - Holding buffer is unaffected; a completed word survives clear and still obeys drain.
- word_ready while word_valid=0 has no effect.
- Async reset mid-word or with a held word discards everything immediately.
- Partial word: bit_count != 0 is the partial indicator for the controller's EOP byte-alignment check.

Test Plan:
- W=8, LSB_FIRST=1, word_ready=1: shift bits 1,0,1,0,0,1,0,1 (0xA5, LSB first) with shift_enable every 4th cycle -> after the 8th sample, next cycle word_valid=1 for exactly one cycle, word_data=0xA5, rcv_data=0xA5, bit_count=0.
- Same stream with a stuff_bit=1, d_orig=1 cycle inserted after bit 6 -> stuff bit ignored; word_data=0xA5; bit_count sequence 1..7 then 0, with no increment on the stuff cycle.
- Backpressure: word_ready=0, send 0x3C then 0xFF -> word_data=0x3C, word_valid=1, and overrun=1 one cycle after the 16th sample. Then word_ready=1 for one cycle -> word_valid=0, overrun stays 1 until clear.
- Simultaneous: hold 0x12 with word_ready=0; raise word_ready on the final-sample cycle of 0x34 -> word_data=0x34, word_valid stays 1, overrun=0.
- Flush: 5 bits sampled then clear=1 together with shift_enable=1 -> bit_count=0, rcv_data=0, bit not captured. A following 0x81 is received correctly. Assert n_rst=0 mid-word -> all outputs 0 asynchronously, before the next clk edge.
- W=16, LSB_FIRST=0: shift 0xBEEF MSB first -> word_data=0xBEEF after the 16th sample, bit_count wraps 15 -> 0.
